div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
Multi-cycle radix-2 integer divider for the execute stage. It implements RV64M DIV, DIVU, REM, REMU and the 32-bit forms DIVW, DIVUW, REMW, REMUW. The block sits beside the single-cycle ALU and performs the arithmetic that ALU cannot do in one cycle. The pipeline stalls on the valid/ready handshake while an operation is in flight.

Parameters:
XLEN, 64, operand and result width; only 64 is supported.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
in_valid  input  1  operation request.
in_ready  output  1  block can accept a request; equals (state==IDLE) && !flush.
is_signed  input  1  1 = signed (DIV/REM), 0 = unsigned.
is_rem  input  1  1 = return remainder, 0 = return quotient.
is_word  input  1  1 = W variant: use a[31:0] and b[31:0], sign-extend result from bit 31.
a  input  XLEN  dividend.
b  input  XLEN  divisor.
flush  input  1  squash the in-flight operation.
out_valid  output  1  result available.
out_ready  input  1  consumer takes result.
result  output  XLEN  quotient or remainder.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, out_valid=0, result=0, all internal registers cleared.
- States: IDLE, RUN, DONE.
- IDLE: in_valid && in_ready accepts the request and latches the operands.
  - W variant: operands are first sign-extended (is_signed=1) or zero-extended (is_signed=0) from bit 31.
  - Signed operation: latch |a|, |b|, the quotient sign (sign_a ^ sign_b) and the remainder sign (sign_a).
  - Load the iteration counter with 64, or 32 when is_word=1.
- Special cases are detected at accept and go to DONE next cycle with the result preloaded:
  - b==0 (width-masked): quotient = all ones, remainder = a (extended form).
  - Signed overflow, i.e. a==most-negative and b==-1 at the operating width: quotient = a, remainder = 0.
- Normal case: IDLE → RUN.
- RUN: each cycle performs one restoring step:
  - rem = {rem, dividend MSB}; if rem >= divisor then subtract and shift in quotient bit 1, else shift in 0.
  - Counter decrements; on the step where counter==1, go to DONE.
- DONE entry: quotient and remainder are sign-fixed (negated if the latched sign is 1). Result selected by is_rem; W results are sign-extended from bit 31 in all cases, including DIVUW and REMUW.
- Latency, accept at cycle 0: out_valid at cycle 65 (64-bit), cycle 33 (W), cycle 1 (special case).
- DONE: out_valid=1 and result is held stable until out_valid && out_ready. On handshake, next state is IDLE with out_valid=0. No new accept in the same cycle; accepts resume the following cycle.
- Flush: from any state, next state is IDLE with out_valid=0. A result presented in the same cycle as flush is dropped even if out_ready=1. Since in_ready=0 while flush=1, a request during flush is not accepted.
- Reset asserted mid-RUN abandons the operation immediately.
- Ignored inputs: is_signed, is_rem, is_word, a and b are ignored outside the accept cycle. Changes to them during RUN or DONE have no effect.

Test Plan:
- DIV a=100, b=7, accept at cycle 0 → out_valid rises at cycle 65, result=14. REM with a=-100 → result=-2 (0xFFFF_FFFF_FFFF_FFFE).
- DIVU a=5, b=0 → out_valid at cycle 1, result=0xFFFF_FFFF_FFFF_FFFF. REMU a=5, b=0 → result=5.
- DIV a=0x8000_0000_0000_0000, b=-1 → cycle 1, result=0x8000_0000_0000_0000. REM → result=0. REMW a=0x8000_0000, b=-1 → result=0.
- DIVW a=0x0000_0001_8000_0000, b=2 → out_valid at cycle 33, result=0xFFFF_FFFF_C000_0000. DIVUW with the same operands → result=0x0000_0000_4000_0000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result and out_valid stay constant. Then out_ready=1 → IDLE next cycle and in_ready=1 the cycle after.
- Flush at cycle 10 of a 64-bit op → IDLE at cycle 11, no out_valid ever seen. A new DIVU 9/2 accepted at cycle 11 → result=4 at cycle 76. Also pull reset low mid-RUN → out_valid=0 and in_ready=1 after release.

Source files
------------

// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the W forms.
// Latency: result 65 cycles after accept (64-bit), 33 (W), 1 (div-by-zero or signed overflow).
// Backpressure: result held in DONE until out_ready; flush squashes any state, in_ready low while busy or flushing.
// Ports: clk/reset (async active-low); in_valid/in_ready request handshake with is_signed, is_rem,
//        is_word, a, b; flush squashes; out_valid/out_ready result handshake with result.
module div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic            is_word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] dvd;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [XLEN-1:0] dvs;      // |divisor|
  logic [XLEN-1:0] rem;      // partial remainder
  logic [6:0]      cnt;
  logic            neg_q;
  logic            neg_r;
  logic            l_rem;
  logic            l_word;

  // W results are always sign-extended from bit 31, unsigned forms included.
  function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] v, input logic w);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  // Accept-side operand preparation
  logic [XLEN-1:0] ea, eb, abs_a, abs_b, min_neg, special_res;
  logic            sa, sb, div_zero, ovf;

  always_comb begin
    if (is_word) begin
      ea = is_signed ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
      eb = is_signed ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
    end else begin
      ea = a;
      eb = b;
    end
    sa       = is_signed & ea[XLEN-1];
    sb       = is_signed & eb[XLEN-1];
    abs_a    = sa ? -ea : ea;
    abs_b    = sb ? -eb : eb;
    min_neg  = is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    div_zero = (eb == '0);
    ovf      = is_signed && (ea == min_neg) && (eb == '1);
    if (div_zero)
      special_res = is_rem ? ea : '1;
    else
      special_res = is_rem ? '0 : ea;
    special_res = wfix(special_res, is_word);
  end

  // One restoring step. The shifted remainder needs 65 bits because an unsigned
  // divisor can use all 64 bits.
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;
  logic [XLEN-1:0] rem_nx, q_nx, fin_q, fin_r, fin;

  always_comb begin
    rem_sh = {rem, dvd[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs};
    ge     = (rem_sh >= {1'b0, dvs});
    rem_nx = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    q_nx   = {dvd[XLEN-2:0], ge};
    fin_q  = neg_q ? -q_nx : q_nx;
    fin_r  = neg_r ? -rem_nx : rem_nx;
    fin    = wfix(l_rem ? fin_r : fin_q, l_word);
  end

  assign in_ready = (state == IDLE) && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      l_rem     <= 1'b0;
      l_word    <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // W operands sit in the upper half so the 32 steps consume them MSB first.
            dvd    <= is_word ? {abs_a[31:0], 32'b0} : abs_a;
            dvs    <= abs_b;
            rem    <= '0;
            cnt    <= is_word ? 7'd32 : 7'd64;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            l_rem  <= is_rem;
            l_word <= is_word;
            if (div_zero || ovf) begin
              result    <= special_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_nx;
          dvd <= q_nx;
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) begin
            result    <= fin;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        is_signed = 1'b0;
  logic        is_rem = 1'b0;
  logic        is_word = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;

  int tests = 0;
  int fails = 0;

  div_unit #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .is_signed(is_signed), .is_rem(is_rem), .is_word(is_word), .a(a), .b(b),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request in one cycle; scramble the operand inputs after the accept edge.
  task automatic start_op(input string tag, input logic s, input logic r, input logic w,
                          input logic [63:0] av, input logic [63:0] bv);
    @(negedge clk);
    check({tag, "/in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "/idle_ov"}, 64'(out_valid), 64'd0);
    is_signed = s; is_rem = r; is_word = w; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    is_signed = ~s; is_rem = ~r; is_word = ~w; a = ~av; b = 64'd3;
  endtask

  // Cycles counted from the accept edge; bounded wait.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 300);
  endtask

  task automatic run_op(input string tag, input logic s, input logic r, input logic w,
                        input logic [63:0] av, input logic [63:0] bv,
                        input logic [63:0] exp, input int exp_lat);
    int lat;
    start_op(tag, s, r, w, av, bv);
    wait_valid(lat);
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/result"}, result, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    // Reset state
    #12;
    check("reset/out_valid", 64'(out_valid), 64'd0);
    check("reset/result", result, 64'd0);
    check("reset/in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;

    // Normal 64-bit signed/unsigned
    run_op("div_100_7",    1, 0, 0, 64'd100, 64'd7, 64'd14, 65);
    run_op("rem_m100_7",   1, 1, 0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("div_m7_2",     1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem_m7_2",     1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divu_max_msb", 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd1, 65);
    run_op("remu_max_msb", 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
           64'h7FFF_FFFF_FFFF_FFFF, 65);

    // Divide by zero and signed overflow
    run_op("divu_5_0", 0, 0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_5_0", 0, 1, 0, 64'd5, 64'd0, 64'd5, 1);
    run_op("div_ovf",  1, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf",  1, 1, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("remw_ovf", 1, 1, 1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);

    // Word forms
    run_op("divw",    1, 0, 1, 64'h0000_0001_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 33);
    run_op("divuw",   0, 0, 1, 64'h0000_0001_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 33);
    run_op("divuw_sx", 0, 0, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);

    // Backpressure: result held while out_ready is low
    start_op("bp", 1, 0, 0, 64'd100, 64'd7);
    wait_valid(lat);
    check("bp/latency", 64'(lat), 64'd65);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp/hold_ov", 64'(out_valid), 64'd1);
      check("bp/hold_res", result, 64'd14);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp/after_ov", 64'(out_valid), 64'd0);
    check("bp/after_rdy", 64'(in_ready), 64'd1);

    // Flush at cycle 10 of a 64-bit operation, then new op accepted at cycle 11
    start_op("fl", 1, 0, 0, 64'd100, 64'd7);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("fl/no_ov", 64'(out_valid), 64'd0);
      check("fl/busy", 64'(in_ready), 64'd0);
    end
    flush = 1'b1;
    #1;
    check("fl/rdy_in_flush", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    run_op("fl_divu_9_2", 0, 0, 0, 64'd9, 64'd2, 64'd4, 65);

    // Flush drops a presented result even with out_ready high
    start_op("fld", 0, 0, 0, 64'd5, 64'd0);
    wait_valid(lat);
    check("fld/latency", 64'(lat), 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("fld/ov", 64'(out_valid), 64'd0);
    check("fld/rdy", 64'(in_ready), 64'd1);

    // Reset mid-RUN
    start_op("rst", 0, 0, 0, 64'd1000, 64'd3);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst/ov", 64'(out_valid), 64'd0);
    check("rst/res", result, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst/ov_after", 64'(out_valid), 64'd0);
    check("rst/rdy_after", 64'(in_ready), 64'd1);
    run_op("remu_9_2", 0, 1, 0, 64'd9, 64'd2, 64'd1, 65);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
